// File: rtl/q_sys_spi_rxm_seq.sv
// q_sys_spi_rxm_seq: turns a framed TX byte stream into q_sys_spi_rxm register
// accesses and buffers the echoed RX bytes in a small FIFO for a valid/ready consumer.
module q_sys_spi_rxm_seq #(
  parameter int RX_DEPTH        = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_last,
  input  logic        rx_ready,
  output logic        spi_select,
  output logic [2:0]  mem_addr,
  output logic        read_n,
  output logic        write_n,
  output logic [15:0] data_from_cpu,
  input  logic [15:0] data_to_cpu,
  input  logic        dataavailable,
  input  logic        readyfordata,
  output logic        busy
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] MAX_O = 2'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] DEPTH_C = CW'(RX_DEPTH);
  typedef enum logic [2:0] {IDLE, SS_ON, RUN, RD, WR, SS_OFF} state_e;
  state_e state_q, state_d, pick;
  logic [1:0] ph_q, ph_d, out_q, out_d;
  logic last_q, last_d;
  logic sel_q, sel_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, txr_q, txr_d, busy_q, busy_d;
  logic [2:0] addr_q, addr_d;
  logic [15:0] dout_q, dout_d;
  logic [8:0] mem_q [RX_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, cnt_d, free;
  logic acc_q, acc_d, strb_d, push, pop, unused_hi;
  assign unused_hi = ^data_to_cpu[15:8];
  assign acc_q = state_q inside {SS_ON, RD, WR, SS_OFF};
  // The gap cycle of an access doubles as the RUN decision point, so back-to-back accesses are 3 cycles apart.
  always_comb begin
    free = DEPTH_C - cnt_q;
    pick = (dataavailable && out_q != 2'd0) ? RD :
           (tx_valid && readyfordata && !last_q && out_q < MAX_O && free > CW'(out_q)) ? WR :
           (last_q && out_q == 2'd0) ? SS_OFF : RUN;
    state_d = state_q == IDLE ? (tx_valid ? SS_ON : IDLE) :
              state_q == RUN ? pick :
              ph_q != 2'd2 ? state_q :
              state_q == SS_OFF ? IDLE : pick;
    ph_d = (acc_q && ph_q != 2'd2) ? ph_q + 2'd1 : 2'd0;
    acc_d = state_d inside {SS_ON, RD, WR, SS_OFF};
    strb_d = acc_d && ph_d != 2'd2;
    sel_d = acc_d;
    rd_n_d = !(strb_d && state_d == RD);
    wr_n_d = !(strb_d && state_d != RD);
    addr_d = !strb_d ? addr_q : state_d == RD ? 3'd0 : state_d == WR ? 3'd1 : 3'd3;
    dout_d = !strb_d ? dout_q : state_d == WR ? {8'h00, tx_data} :
             state_d == SS_ON ? 16'h0400 : 16'h0000;
    txr_d = state_d == WR && ph_d == 2'd0;
    busy_d = state_d != IDLE;
    push = state_q == RD && ph_q == 2'd1;
    pop = cnt_q != '0 && rx_ready;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    out_d = (state_q == WR && ph_q == 2'd0) ? out_q + 2'd1 : push ? out_q - 2'd1 : out_q;
    last_d = (state_q == WR && ph_q == 2'd0 && tx_last) ? 1'b1 :
             (state_q == SS_OFF && ph_q == 2'd2) ? 1'b0 : last_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ph_q    <= '0;
      out_q   <= '0;
      last_q  <= 1'b0;
      sel_q   <= 1'b0;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      txr_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      out_q   <= out_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      txr_q   <= txr_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      if (push) begin
        mem_q[wp_q] <= {out_q == 2'd1 && last_q, data_to_cpu[7:0]};
        wp_q        <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
    end
  end
  assign tx_ready      = txr_q;
  assign rx_data       = mem_q[rp_q][7:0];
  assign rx_last       = mem_q[rp_q][8];
  assign rx_valid      = cnt_q != '0;
  assign spi_select    = sel_q;
  assign mem_addr      = addr_q;
  assign read_n        = rd_n_q;
  assign write_n       = wr_n_q;
  assign data_from_cpu = dout_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_q_sys_spi_rxm_seq.sv
// tb_q_sys_spi_rxm_seq: directed packets against a transaction-level SPI master and scoreboard model.
module tb_q_sys_spi_rxm_seq;
  localparam int DEPTH = 4;
  localparam int MAXO = 2;
  localparam int LAT = 5;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_last = 1'b0;
  logic tx_ready;
  logic [7:0] rx_data;
  logic rx_valid, rx_last;
  logic rx_ready = 1'b1;
  logic spi_select, read_n, write_n, busy;
  logic [2:0] mem_addr;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu = 16'hEEEE;
  logic dataavailable = 1'b0;
  logic readyfordata = 1'b1;

  q_sys_spi_rxm_seq #(.RX_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last),
    .rx_ready(rx_ready), .spi_select(spi_select), .mem_addr(mem_addr), .read_n(read_n),
    .write_n(write_n), .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
    .dataavailable(dataavailable), .readyfordata(readyfordata), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {logic [7:0] d; logic last; int gap;} tx_t;
  typedef struct {logic w; logic [2:0] a; logic [15:0] d; int cyc;} acc_t;
  typedef struct {logic [7:0] d; int due;} pend_t;
  tx_t txq[$];
  acc_t log_q[$];
  logic [8:0] expq[$];
  pend_t pend[$];
  logic [7:0] rxq[$];
  int cyc = 0, low_cnt = 0, out_m = 0, fifo_m = 0, max_out = 0, ss_off_cnt = 0, wr1_cnt = 0;
  logic [2:0] a_addr;
  logic [15:0] a_data;
  logic rd_pop = 1'b0;
  logic toggle = 1'b0;
  logic [8:0] last_rx = '0;
  acc_t ent;
  pend_t pe;

  // Transaction-level master: echoes each written byte XOR 0x99 after LAT cycles; also checks every cycle.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      pend.delete(); rxq.delete(); expq.delete();
      low_cnt = 0; out_m = 0; fifo_m = 0; rd_pop = 1'b0;
    end else begin
      chk("rx_valid", rx_valid, fifo_m > 0);
      if (spi_select) chk("busy_in_acc", busy, 1);
      if (rx_valid && rx_ready) begin
        if (expq.size() == 0) chk("rx_extra_byte", expq.size(), 1);
        else begin
          chk("rx_data", rx_data, expq[0][7:0]);
          chk("rx_last", rx_last, expq[0][8]);
          void'(expq.pop_front());
        end
        last_rx = {rx_last, rx_data};
        fifo_m--;
      end
      if (!read_n || !write_n) begin
        low_cnt++;
        chk("strobe_sel", spi_select, 1);
        chk("one_strobe", read_n ^ write_n, 1);
        chk("strobe_len", low_cnt <= 2, 1);
        if (low_cnt == 1) begin
          a_addr = mem_addr;
          a_data = data_from_cpu;
        end else begin
          chk("b_addr", mem_addr, a_addr);
          chk("b_data", data_from_cpu, a_data);
        end
        if (low_cnt == 2) begin
          ent.w = !write_n; ent.a = mem_addr; ent.d = data_from_cpu; ent.cyc = cyc - 1;
          log_q.push_back(ent);
          if (!write_n && mem_addr == 3'd1) begin
            pe.d = data_from_cpu[7:0] ^ 8'h99; pe.due = cyc + LAT;
            pend.push_back(pe);
            out_m++; wr1_cnt++;
          end
          if (!write_n && mem_addr == 3'd3 && data_from_cpu == 16'h0000) ss_off_cnt++;
          if (!read_n) begin
            chk("rd_addr", mem_addr, 0);
            chk("rd_has_data", rxq.size() > 0, 1);
            out_m--; fifo_m++; rd_pop = 1'b1;
            chk("out_nonneg", out_m >= 0, 1);
          end
          chk("out_max", out_m <= MAXO, 1);
          chk("no_overrun", out_m + fifo_m <= DEPTH, 1);
          if (out_m > max_out) max_out = out_m;
        end
      end else begin
        if (low_cnt != 0) begin
          chk("strobe_cycles", low_cnt, 2);
          chk("gap_sel", spi_select, 1);
        end
        if (rd_pop) begin
          if (rxq.size() > 0) void'(rxq.pop_front());
          rd_pop = 1'b0;
        end
        low_cnt = 0;
      end
      chk("tx_ready", tx_ready, !write_n && mem_addr == 3'd1 && low_cnt == 1);
      while (pend.size() > 0 && pend[0].due <= cyc) begin
        pe = pend.pop_front();
        rxq.push_back(pe.d);
      end
    end
    dataavailable = rxq.size() > 0;
    data_to_cpu = rxq.size() > 0 ? {8'hEE, rxq[0]} : 16'hEEEE;
    readyfordata = !(toggle && low_cnt == 1);
  end

  // TX source: holds each byte until tx_ready, then presents the next after the clock edge.
  initial begin
    logic took;
    tx_t t;
    forever begin
      @(negedge clk);
      took = tx_ready && tx_valid;
      @(posedge clk);
      #1;
      if (took && txq.size() > 0) void'(txq.pop_front());
      if (txq.size() == 0) tx_valid = 1'b0;
      else if (txq[0].gap > 0) begin
        t = txq.pop_front();
        t.gap--;
        txq.push_front(t);
        tx_valid = 1'b0;
      end else begin
        tx_valid = 1'b1;
        tx_data = txq[0].d;
        tx_last = txq[0].last;
      end
    end
  end

  task automatic add(input logic [7:0] d, input logic last, input int gap);
    tx_t t;
    t.d = d; t.last = last; t.gap = gap;
    txq.push_back(t);
    expq.push_back({last, d ^ 8'h99});
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy == 1'b0 && txq.size() == 0 && expq.size() == 0) && n < 3000);
    chk({nm, " completes"}, busy == 1'b0 && txq.size() == 0 && expq.size() == 0, 1);
  endtask

  task automatic chk_rst(input string p);
    chk({p, " spi_select"}, spi_select, 0);
    chk({p, " read_n"}, read_n, 1);
    chk({p, " write_n"}, write_n, 1);
    chk({p, " mem_addr"}, mem_addr, 0);
    chk({p, " data_from_cpu"}, data_from_cpu, 0);
    chk({p, " tx_ready"}, tx_ready, 0);
    chk({p, " rx_valid"}, rx_valid, 0);
    chk({p, " rx_data"}, rx_data, 0);
    chk({p, " rx_last"}, rx_last, 0);
    chk({p, " busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, n2, k;
    int w1c[$];
    logic [7:0] w1d[$];
    logic [19:0] exp1[4];
    logic [7:0] b4[4];
    exp1[0] = {1'b1, 3'd3, 16'h0400};
    exp1[1] = {1'b1, 3'd1, 16'h00A5};
    exp1[2] = {1'b0, 3'd0, 16'h0000};
    exp1[3] = {1'b1, 3'd3, 16'h0000};
    b4[0] = 8'h11; b4[1] = 8'h22; b4[2] = 8'h33; b4[3] = 8'h44;
    repeat (2) @(negedge clk);
    #1;
    chk_rst("reset");
    reset_n = 1'b1;

    log_q.delete();
    add(8'hA5, 1'b1, 0);
    wait_done("single", n1);
    chk("single access count", log_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("single access %0d", i),
          i < log_q.size() ? {log_q[i].w, log_q[i].a, (log_q[i].w ? log_q[i].d : 16'h0000)} : 20'hFFFFF,
          exp1[i]);
    chk("single rx byte", last_rx, 9'h13C);

    log_q.delete(); max_out = 0;
    for (int i = 0; i < 4; i++) add(b4[i], i == 3, 0);
    wait_done("four", n1);
    chk("four max outstanding", max_out, 2);
    w1c.delete(); w1d.delete();
    foreach (log_q[i]) if (log_q[i].w && log_q[i].a == 3'd1) begin
      w1c.push_back(log_q[i].cyc);
      w1d.push_back(log_q[i].d[7:0]);
    end
    chk("four tx writes", w1c.size(), 4);
    chk("four back-to-back spacing", w1c.size() > 1 ? w1c[1] - w1c[0] : -1, 3);
    for (int i = 0; i < 4; i++) chk($sformatf("four tx order %0d", i), i < w1d.size() ? w1d[i] : 8'hXX, b4[i]);
    chk("four last rx", last_rx, 9'h1DD);

    @(posedge clk); #1; rx_ready = 1'b0;
    wr1_cnt = 0; ss_off_cnt = 0;
    for (int i = 1; i <= 6; i++) add(8'(i), i == 6, 0);
    repeat (80) @(negedge clk);
    chk("bp stalled writes", wr1_cnt, 4);
    chk("bp rx_valid held", rx_valid, 1);
    chk("bp no release", ss_off_cnt, 0);
    @(posedge clk); #1; rx_ready = 1'b1;
    wait_done("backpressure", n2);
    chk("bp total writes", wr1_cnt, 6);
    chk("bp last rx", last_rx, 9'h19F);

    wr1_cnt = 0; ss_off_cnt = 0;
    add(8'h71, 1'b0, 0); add(8'h72, 1'b0, 50); add(8'h73, 1'b1, 0);
    k = 0;
    while (wr1_cnt < 1 && k < 200) begin @(negedge clk); k++; end
    chk("gap first write", wr1_cnt >= 1, 1);
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      chk("gap busy", busy, 1);
    end
    chk("gap no release", ss_off_cnt, 0);
    chk("gap writes held", wr1_cnt, 1);
    wait_done("gap", n2);
    chk("gap release once", ss_off_cnt, 1);

    ss_off_cnt = 0;
    add(8'h81, 1'b0, 0); add(8'h82, 1'b0, 0); add(8'h83, 1'b1, 0);
    k = 0;
    while (!(!write_n && mem_addr == 3'd1 && !tx_ready) && k < 200) begin @(negedge clk); k++; end
    chk("rst found wr cycle b", !write_n && mem_addr == 3'd1 && !tx_ready, 1);
    #1; reset_n = 1'b0; txq.delete();
    @(negedge clk); #1;
    chk_rst("midreset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midreset no release", ss_off_cnt, 0);
    add(8'h5A, 1'b1, 0);
    wait_done("after reset", n2);
    chk("after reset rx", last_rx, 9'h1C3);

    log_q.delete();
    for (int i = 0; i < 4; i++) add(b4[i], i == 3, 0);
    wait_done("four repeat", n1);
    toggle = 1'b1;
    for (int i = 0; i < 4; i++) add(b4[i], i == 3, 0);
    wait_done("toggle", n2);
    toggle = 1'b0;
    chk("toggle same duration", n2, n1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
